// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry look-ahead blocks:
// slice width and the sequencer state encoding.
package cla_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seqState_e;

endpackage

// File: rtl/struct_4bit_carry_look_ahead_adder.sv
// Combinational 4-bit carry look-ahead slice: all carries are formed
// directly from generate/propagate terms, with no ripple between bits.
module struct_4bit_carry_look_ahead_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g    = A & B;
    assign p    = A ^ B;
    assign c[0] = Cin;

    // Each carry is a flattened sum of products over the lower bit positions.
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign Sum  = p ^ c[3:0];
    assign Cout = c[4];

endmodule

// File: rtl/cla_word_sequencer.sv
// Word-width adder built from one 4-bit CLA slice reused once per nibble,
// LSB nibble first, with the carry chained through a register.
module cla_word_sequencer
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    seqState_e state_q, state_d;

    logic [WIDTH-1:0] aSh_q, aSh_d;
    logic [WIDTH-1:0] bSh_q, bSh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] nibCnt_q, nibCnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] sliceSum;
    logic                sliceCout;
    logic                lastNib;
    logic                mSbCarryIn;

    assign lastNib = (nibCnt_q == LAST_NIB);

    struct_4bit_carry_look_ahead_adder u_slice (
        .A    (aSh_q[NIBBLE_W-1:0]),
        .B    (bSh_q[NIBBLE_W-1:0]),
        .Cin  (carry_q),
        .Sum  (sliceSum),
        .Cout (sliceCout)
    );

    // Carry into the word MSB recovered from the top bit's own sum: s = a ^ b ^ cin.
    assign mSbCarryIn = aSh_q[NIBBLE_W-1] ^ bSh_q[NIBBLE_W-1] ^ sliceSum[NIBBLE_W-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid_i)  state_d = RUN;
            RUN:     if (lastNib)     state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs depend on the state register alone.
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            IDLE:    in_ready_o  = 1'b1;
            DONE:    out_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        aSh_d    = aSh_q;
        bSh_d    = bSh_q;
        sum_d    = sum_q;
        nibCnt_d = nibCnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    aSh_d    = a_i;
                    bSh_d    = b_i;
                    carry_d  = cin_i;
                    sum_d    = '0;
                    nibCnt_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                end
            end
            RUN: begin
                aSh_d   = aSh_q >> NIBBLE_W;
                bSh_d   = bSh_q >> NIBBLE_W;
                sum_d   = {sliceSum, sum_q[WIDTH-1:NIBBLE_W]};
                carry_d = sliceCout;
                if (lastNib) begin
                    cout_d = sliceCout;
                    ovf_d  = mSbCarryIn ^ sliceCout;
                end else begin
                    nibCnt_d = nibCnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aSh_q    <= '0;
            bSh_q    <= '0;
            sum_q    <= '0;
            nibCnt_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            aSh_q    <= aSh_d;
            bSh_q    <= bSh_d;
            sum_q    <= sum_d;
            nibCnt_q <= nibCnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: doc/cla_word_sequencer.md
# cla_word_sequencer

Multi-cycle controller that adds WIDTH-bit operands by time-multiplexing a single 4-bit carry look-ahead adder slice, one nibble per clock, least-significant nibble first, chaining the carry through a register. Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. Trades latency for area against a full-width adder.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8
- NIBBLES, WIDTH/4, derived localparam; number of slice passes per operation
- clk  in  1  single clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands and carry-in valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A, unsigned or two's complement
- b  in  WIDTH  operand B
- cin  in  1  carry into bit 0
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result, registered
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  two's-complement overflow, carry into MSB XOR cout

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, cin into shift registers, clear sum register and nibble counter, go to RUN.
- RUN: slice adds nibble 0 of the A/B shift registers plus the carry register. Result nibble shifts into sum from the MSB end. Slice Cout loads the carry register. A/B shift right by 4. Counter increments.
- When counter reaches NIBBLES-1 in RUN, go to DONE on that edge. On the same edge, latch cout and ovf. ovf is the XOR of the MSB carry-in and carry-out, computed from the top nibble's inputs and sum.
- DONE: out_valid=1; sum, cout and ovf are stable. On out_ready, go to IDLE.
- sum, cout and ovf keep their values in IDLE until the next accept. On accept they clear to 0.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- No bypass: in DONE, in_ready=0 even when out_ready=1. A new accept is possible one cycle after the DONE→IDLE edge.
- Arithmetic is modulo 2^WIDTH. cout is the WIDTH+1-th bit.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry register=0, counter=0.
- Reset takes effect immediately and asynchronously from any state, including mid-RUN. Partial results are discarded and not reported.
- Accept at edge E0. RUN occupies edges E1..E_NIBBLES. out_valid rises after edge E_NIBBLES.
- Latency from accept edge to out_valid is NIBBLES edges; for WIDTH=16 this is 4.
- Throughput is one operation per NIBBLES+2 cycles with out_ready tied high.
- in_ready and out_valid are decoded from the state register only; neither has a combinational path from any input.
- Counter width is clog2(NIBBLES) and never wraps within an operation.

## Structure
- Shared package cla_pkg holds:
  - the state encoding constants for IDLE, RUN and DONE
  - NIBBLE_W=4, shared by all slice-based blocks
- One sub-module, instantiated once: struct_4bit_carry_look_ahead_adder, the existing combinational 4-bit CLA slice (ports A, B, Cin, Sum, Cout).
- All sequencing, shifting and flag logic lives in cla_word_sequencer.

## Test plan
- WIDTH=16, a=0x000B, b=0x000D, cin=0, out_ready=1 → sum=0x0018, cout=0, ovf=0; out_valid rises exactly 4 edges after accept and stays high for one cycle.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- a=0xFFFF, b=0xFFFF, cin=1 → sum=0xFFFF, cout=1, ovf=0. Carry propagates through all four nibbles.
- Hold out_ready=0 for 3 cycles in DONE while pulsing in_valid with new operands:
  - out_valid stays 1, sum/cout/ovf stay stable, in_ready stays 0, new operands are not taken;
  - after out_ready=1, in_ready returns 1 on the next cycle.
- Assert rst_n=0 for 1 cycle at the second RUN edge of an operation → outputs immediately 0, in_ready=1; no out_valid ever appears for that operation. The next operation 0x1234+0x4321 gives sum=0x5555, cout=0, ovf=0.
- Random regression, ≥1000 operations with random out_ready backpressure → every result matches a+b+cin reference model.
